// File: rtl/tug_match_controller.sv
// tug_match_controller: match sequencer and pull arbiter for the tug-of-war game,
// turning button edges into single-cycle rope move strobes and tracking scores.
module tug_match_controller #(
  parameter int TICK_DIV     = 100_000_000,
  parameter int COOLDOWN_CYC = 5_000_000,
  parameter int COUNT_START  = 3,
  parameter int HOLD_TICKS   = 2,
  parameter int WIN_SCORE    = 3,
  parameter int LEFT_LIMIT   = 0,
  parameter int RIGHT_LIMIT  = 640
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       p1_btn,
  input  logic       p2_btn,
  input  logic [9:0] rope_pos_x,
  output logic       move_left,
  output logic       move_right,
  output logic       pos_reset,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [1:0] p1_score,
  output logic [1:0] p2_score,
  output logic [1:0] winner
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int CW = $clog2(COOLDOWN_CYC + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  typedef enum logic [2:0] {IDLE, COUNTDOWN, PLAY, ROUND_END, MATCH_END} state_t;
  state_t st;
  logic start_q, p1_q, p2_q;
  logic [TW-1:0] tick_cnt;
  logic [CW-1:0] p1_cd, p2_cd;
  logic [HW-1:0] hold;
  logic start_ev, p1_acc, p2_acc, tick, left_hit, right_hit, timing;
  assign start_ev  = start_btn & ~start_q;
  assign p1_acc    = p1_btn & ~p1_q & (p1_cd == '0);
  assign p2_acc    = p2_btn & ~p2_q & (p2_cd == '0);
  assign tick      = tick_cnt == TW'(TICK_DIV - 1);
  assign timing    = (st == COUNTDOWN) || (st == ROUND_END);
  assign left_hit  = rope_pos_x <= 10'(LEFT_LIMIT);
  assign right_hit = rope_pos_x >= 10'(RIGHT_LIMIT);
  assign state     = st;
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      start_q    <= 1'b0;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      tick_cnt   <= '0;
      p1_cd      <= '0;
      p2_cd      <= '0;
      hold       <= '0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      pos_reset  <= 1'b0;
      countdown  <= 2'd0;
      p1_score   <= 2'd0;
      p2_score   <= 2'd0;
      winner     <= 2'b00;
    end else begin
      start_q    <= start_btn;
      p1_q       <= p1_btn;
      p2_q       <= p2_btn;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      pos_reset  <= 1'b0;
      // Tick counter restarts on every state change since all timed exits happen on a tick
      tick_cnt   <= (timing && !tick) ? tick_cnt + TW'(1) : '0;
      p1_cd      <= (p1_cd != '0) ? p1_cd - CW'(1) : '0;
      p2_cd      <= (p2_cd != '0) ? p2_cd - CW'(1) : '0;
      case (st)
        IDLE: if (start_ev) begin
          st        <= COUNTDOWN;
          countdown <= 2'(COUNT_START);
          pos_reset <= 1'b1;
        end
        COUNTDOWN: begin
          p1_cd <= '0;
          p2_cd <= '0;
          if (tick) begin
            countdown <= countdown - 2'd1;
            if (countdown == 2'd1) st <= PLAY;
          end
        end
        PLAY: if (left_hit) begin
          p1_score <= (p1_score == 2'(WIN_SCORE)) ? p1_score : p1_score + 2'd1;
          hold     <= HW'(HOLD_TICKS);
          st       <= ROUND_END;
        end else if (right_hit) begin
          p2_score <= (p2_score == 2'(WIN_SCORE)) ? p2_score : p2_score + 2'd1;
          hold     <= HW'(HOLD_TICKS);
          st       <= ROUND_END;
        end else begin
          if (p1_acc) p1_cd <= CW'(COOLDOWN_CYC);
          if (p2_acc) p2_cd <= CW'(COOLDOWN_CYC);
          move_left  <= p1_acc & ~p2_acc;
          move_right <= p2_acc & ~p1_acc;
        end
        ROUND_END: if (p1_score == 2'(WIN_SCORE)) begin
          st     <= MATCH_END;
          winner <= 2'b01;
        end else if (p2_score == 2'(WIN_SCORE)) begin
          st     <= MATCH_END;
          winner <= 2'b10;
        end else if (tick) begin
          hold <= hold - HW'(1);
          if (hold == HW'(1)) begin
            st        <= COUNTDOWN;
            countdown <= 2'(COUNT_START);
            pos_reset <= 1'b1;
          end
        end
        MATCH_END: if (start_ev) begin
          p1_score  <= 2'd0;
          p2_score  <= 2'd0;
          winner    <= 2'b00;
          st        <= COUNTDOWN;
          countdown <= 2'(COUNT_START);
          pos_reset <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tug_match_controller.sv
// tb_tug_match_controller: directed-vector bench for the tug-of-war match controller
// using small timing parameters so whole matches fit in a few hundred cycles.
module tb_tug_match_controller;
  logic clk_100mhz, reset, start_btn, p1_btn, p2_btn;
  logic [9:0] rope_pos_x;
  logic move_left, move_right, pos_reset;
  logic [2:0] state;
  logic [1:0] countdown, p1_score, p2_score, winner;
  int checks = 0;
  int errors = 0;
  tug_match_controller #(
    .TICK_DIV(4), .COOLDOWN_CYC(3), .COUNT_START(3), .HOLD_TICKS(1), .WIN_SCORE(2),
    .LEFT_LIMIT(0), .RIGHT_LIMIT(640)
  ) dut (
    .clk_100mhz(clk_100mhz), .reset(reset), .start_btn(start_btn), .p1_btn(p1_btn),
    .p2_btn(p2_btn), .rope_pos_x(rope_pos_x), .move_left(move_left), .move_right(move_right),
    .pos_reset(pos_reset), .state(state), .countdown(countdown), .p1_score(p1_score),
    .p2_score(p2_score), .winner(winner)
  );
  initial begin
    clk_100mhz = 1'b0;
    forever #5 clk_100mhz = ~clk_100mhz;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100mhz);
      #1;
    end
  endtask
  task automatic pulse(input int which);
    if (which == 0) start_btn = 1'b1;
    if (which == 1) p1_btn = 1'b1;
    if (which == 2) p2_btn = 1'b1;
    ticks(1);
  endtask
  initial begin
    reset = 1'b1; start_btn = 0; p1_btn = 0; p2_btn = 0; rope_pos_x = 10'd320;
    ticks(2);
    check("rst_state", state, 0);
    check("rst_strobes", {move_left, move_right, pos_reset}, 0);
    check("rst_count", countdown, 0);
    check("rst_scores", {p1_score, p2_score, winner}, 0);
    reset = 1'b0;
    ticks(1);
    pulse(0);
    check("start_state", state, 1);
    check("start_posrst", pos_reset, 1);
    check("start_count", countdown, 3);
    start_btn = 0;
    ticks(1);
    check("posrst_once", pos_reset, 0);
    ticks(2);
    check("count3_hold", countdown, 3);
    ticks(1);
    check("count2", countdown, 2);
    pulse(1);
    p1_btn = 0;
    check("no_false_start", move_left, 0);
    p2_btn = 1'b1;
    ticks(3);
    check("count1", countdown, 1);
    ticks(3);
    check("still_countdown", state, 1);
    ticks(1);
    check("play_entered", state, 2);
    check("count0", countdown, 0);
    ticks(1);
    check("held_p2_a", move_right, 0);
    ticks(1);
    check("held_p2_b", move_right, 0);
    p2_btn = 0;
    ticks(1);
    pulse(2);
    check("p2_repress", {move_left, move_right}, 2'b01);
    p2_btn = 0;
    ticks(1);
    check("p2_one_cycle", move_right, 0);
    ticks(3);
    pulse(1);
    check("p1_accept", {move_left, move_right}, 2'b10);
    p1_btn = 0;
    ticks(1);
    check("p1_one_cycle", move_left, 0);
    pulse(1);
    check("p1_cooldown_drop", move_left, 0);
    p1_btn = 0;
    ticks(1);
    pulse(1);
    check("p1_after_cd", move_left, 1);
    p1_btn = 0;
    ticks(4);
    p1_btn = 1; p2_btn = 1;
    ticks(1);
    check("tie_no_strobe", {move_left, move_right}, 0);
    p1_btn = 0; p2_btn = 0;
    ticks(1);
    pulse(2);
    check("tie_p2_locked", move_right, 0);
    p2_btn = 0;
    ticks(1);
    pulse(1);
    check("tie_p1_unlocked", move_left, 1);
    p1_btn = 0;
    pulse(0);
    check("start_in_play", state, 2);
    start_btn = 0;
    ticks(3);
    rope_pos_x = 10'd640; p1_btn = 1;
    ticks(1);
    check("right_round", state, 3);
    check("p2_score1", p2_score, 1);
    check("limit_no_strobe", move_left, 0);
    rope_pos_x = 10'd320; p1_btn = 0;
    ticks(3);
    check("hold_round_end", state, 3);
    ticks(1);
    check("re_countdown", state, 1);
    check("re_posrst", pos_reset, 1);
    check("re_count3", countdown, 3);
    ticks(11);
    check("re_not_play", state, 1);
    ticks(1);
    check("re_play", state, 2);
    rope_pos_x = 10'd700;
    ticks(1);
    check("p2_score2", p2_score, 2);
    rope_pos_x = 10'd320;
    ticks(1);
    check("match_end", state, 4);
    check("winner_p2", winner, 2'b10);
    ticks(5);
    check("match_hold", {state, winner, p2_score}, {3'd4, 2'b10, 2'd2});
    pulse(0);
    check("restart_state", state, 1);
    check("restart_scores", {p1_score, p2_score, winner}, 0);
    check("restart_posrst", pos_reset, 1);
    start_btn = 0;
    ticks(12);
    check("play3", state, 2);
    rope_pos_x = 10'd0;
    ticks(1);
    check("left_round", {state, p1_score, p2_score}, {3'd3, 2'd1, 2'd0});
    rope_pos_x = 10'd320;
    ticks(4);
    check("cd_after_left", state, 1);
    ticks(12);
    check("play4", state, 2);
    p1_btn = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_state", state, 0);
    check("async_strobes", {move_left, move_right, pos_reset}, 0);
    check("async_scores", {p1_score, p2_score, winner, countdown}, 0);
    ticks(1);
    check("async_hold", move_left, 0);
    p1_btn = 0;
    reset = 1'b0;
    ticks(2);
    check("idle_after_rst", state, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
